// File: rtl/ysyx_exu_csr_ctrl.sv
// Purpose: sequences CSRRW/CSRRS/CSRRC/ECALL/MRET through a read-modify-write of the CSR file.
// Latency: accept-to-out_valid is 3 cycles for CSR ops and MRET, 2 for ECALL and 1 for reserved ops.
// Backpressure: one op in flight; in_ready only in IDLE; RESP holds until out_ready.
module ysyx_exu_csr_ctrl #(
  parameter int BIT_W = 32,
  parameter int R_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [R_W-1:0]   csr_addr,
  input  logic [BIT_W-1:0] src,
  input  logic [BIT_W-1:0] pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIT_W-1:0] rd_data,
  output logic             redirect,
  output logic [BIT_W-1:0] npc,
  output logic             csr_exu_valid,
  output logic             csr_wen,
  output logic             csr_ecallen,
  output logic [R_W-1:0]   csr_waddr,
  output logic [R_W-1:0]   csr_waddr_add1,
  output logic [BIT_W-1:0] csr_wdata,
  output logic [BIT_W-1:0] csr_wdata_add1,
  input  logic [BIT_W-1:0] csr_rdata,
  input  logic [BIT_W-1:0] csr_mtvec,
  input  logic [BIT_W-1:0] csr_mepc
);

  localparam logic [2:0] OP_CSRRW = 3'd0;
  localparam logic [2:0] OP_CSRRS = 3'd1;
  localparam logic [2:0] OP_CSRRC = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_MRET  = 3'd4;

  localparam logic [R_W-1:0] ADDR_MSTATUS = R_W'(12'h300);
  localparam logic [R_W-1:0] ADDR_MEPC    = R_W'(12'h341);
  localparam logic [R_W-1:0] ADDR_MCAUSE  = R_W'(12'h342);

  // Machine-mode environment call from M-mode
  localparam logic [BIT_W-1:0] CAUSE_ECALL_M = BIT_W'(11);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [R_W-1:0]   addr_q, addr_d;
  logic [BIT_W-1:0] src_q, src_d;
  logic [BIT_W-1:0] pc_q, pc_d;
  logic [BIT_W-1:0] old_q, old_d;
  logic [BIT_W-1:0] rd_data_q, rd_data_d;
  logic [BIT_W-1:0] npc_q, npc_d;
  logic             redirect_q, redirect_d;

  logic [BIT_W-1:0] mstatus_new;

  // MRET restores MIE from MPIE and sets MPIE
  always_comb begin
    mstatus_new    = old_q;
    mstatus_new[3] = old_q[7];
    mstatus_new[7] = 1'b1;
  end

  // State register and operation/response holding registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      addr_q     <= '0;
      src_q      <= '0;
      pc_q       <= '0;
      old_q      <= '0;
      rd_data_q  <= '0;
      npc_q      <= '0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      src_q      <= src_d;
      pc_q       <= pc_d;
      old_q      <= old_d;
      rd_data_q  <= rd_data_d;
      npc_q      <= npc_d;
      redirect_q <= redirect_d;
    end
  end

  // Next-state: latch op on accept, capture old value in READ, build response in WRITE
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    src_d      = src_q;
    pc_d       = pc_q;
    old_d      = old_q;
    rd_data_d  = rd_data_q;
    npc_d      = npc_q;
    redirect_d = redirect_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d       = op;
          addr_d     = csr_addr;
          src_d      = src;
          pc_d       = pc;
          rd_data_d  = '0;
          npc_d      = '0;
          redirect_d = 1'b0;
          case (op)
            OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_MRET: state_d = S_READ;
            OP_ECALL:                              state_d = S_WRITE;
            default:                               state_d = S_RESP;
          endcase
        end
      end
      S_READ: begin
        old_d = csr_rdata;
        // mepc is the return target; take it while the read is in progress
        if (op_q == OP_MRET) npc_d = csr_mepc;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        case (op_q)
          OP_ECALL: begin
            npc_d      = csr_mtvec;
            redirect_d = 1'b1;
          end
          OP_MRET: redirect_d = 1'b1;
          default: rd_data_d = old_q;
        endcase
        state_d = S_RESP;
      end
      S_RESP: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and CSR-file strobes, decoded from the current state only
  always_comb begin
    in_ready       = (state_q == S_IDLE);
    out_valid      = (state_q == S_RESP);
    rd_data        = rd_data_q;
    npc            = npc_q;
    redirect       = redirect_q & (state_q == S_RESP);
    csr_exu_valid  = 1'b0;
    csr_wen        = 1'b0;
    csr_ecallen    = 1'b0;
    csr_waddr      = '0;
    csr_waddr_add1 = '0;
    csr_wdata      = '0;
    csr_wdata_add1 = '0;
    case (state_q)
      S_READ: begin
        csr_waddr = (op_q == OP_MRET) ? ADDR_MSTATUS : addr_q;
      end
      S_WRITE: begin
        case (op_q)
          OP_CSRRW: begin
            csr_exu_valid = 1'b1;
            csr_wen       = 1'b1;
            csr_waddr     = addr_q;
            csr_wdata     = src_q;
          end
          OP_CSRRS: begin
            csr_exu_valid = 1'b1;
            csr_wen       = |src_q;
            csr_waddr     = addr_q;
            csr_wdata     = old_q | src_q;
          end
          OP_CSRRC: begin
            csr_exu_valid = 1'b1;
            csr_wen       = |src_q;
            csr_waddr     = addr_q;
            csr_wdata     = old_q & ~src_q;
          end
          OP_ECALL: begin
            csr_exu_valid  = 1'b1;
            csr_wen        = 1'b1;
            csr_ecallen    = 1'b1;
            csr_waddr      = ADDR_MEPC;
            csr_wdata      = pc_q;
            csr_waddr_add1 = ADDR_MCAUSE;
            csr_wdata_add1 = CAUSE_ECALL_M;
          end
          OP_MRET: begin
            csr_exu_valid = 1'b1;
            csr_wen       = 1'b1;
            csr_waddr     = ADDR_MSTATUS;
            csr_wdata     = mstatus_new;
          end
          default: begin
            csr_exu_valid = 1'b0;
          end
        endcase
      end
      default: begin
        csr_waddr = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_exu_csr_ctrl.sv
// Directed bench for ysyx_exu_csr_ctrl: CSR ops, ECALL, MRET, reserved op,
// backpressure, back-to-back accept and reset during WRITE.
module tb_ysyx_exu_csr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [11:0] csr_addr;
  logic [31:0] src;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rd_data;
  logic        redirect;
  logic [31:0] npc;
  logic        csr_exu_valid;
  logic        csr_wen;
  logic        csr_ecallen;
  logic [11:0] csr_waddr;
  logic [11:0] csr_waddr_add1;
  logic [31:0] csr_wdata;
  logic [31:0] csr_wdata_add1;
  logic [31:0] csr_rdata;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;

  int total = 0;
  int bad   = 0;

  ysyx_exu_csr_ctrl #(.BIT_W(32), .R_W(12)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .csr_addr(csr_addr), .src(src), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd_data(rd_data), .redirect(redirect), .npc(npc),
    .csr_exu_valid(csr_exu_valid), .csr_wen(csr_wen), .csr_ecallen(csr_ecallen),
    .csr_waddr(csr_waddr), .csr_waddr_add1(csr_waddr_add1),
    .csr_wdata(csr_wdata), .csr_wdata_add1(csr_wdata_add1),
    .csr_rdata(csr_rdata), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] o, input logic [11:0] a, input logic [31:0] s,
                       input logic [31:0] p);
    in_valid = 1'b1;
    op       = o;
    csr_addr = a;
    src      = s;
    pc       = p;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; op = 3'd0; csr_addr = '0; src = '0; pc = '0;
    out_ready = 1'b1; csr_rdata = '0; csr_mtvec = '0; csr_mepc = '0;
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_wen", {31'd0, csr_wen}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_npc", npc, 32'd0);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    rst = 1'b1;

    // CSRRW 0x305 <- 0x8000_0100, old value 0
    offer(3'd0, 12'h305, 32'h8000_0100, 32'h0);
    csr_rdata = 32'h0;
    tick();
    in_valid = 1'b0;
    chk("rw_read_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rw_read_waddr", {20'd0, csr_waddr}, 32'h305);
    chk("rw_read_wen", {31'd0, csr_wen}, 32'd0);
    chk("rw_read_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("rw_wr_exu_valid", {31'd0, csr_exu_valid}, 32'd1);
    chk("rw_wr_wen", {31'd0, csr_wen}, 32'd1);
    chk("rw_wr_waddr", {20'd0, csr_waddr}, 32'h305);
    chk("rw_wr_wdata", csr_wdata, 32'h8000_0100);
    chk("rw_wr_waddr_add1", {20'd0, csr_waddr_add1}, 32'h0);
    chk("rw_wr_wdata_add1", csr_wdata_add1, 32'h0);
    chk("rw_wr_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("rw_resp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("rw_resp_rd_data", rd_data, 32'h0);
    chk("rw_resp_wen", {31'd0, csr_wen}, 32'd0);
    chk("rw_resp_waddr", {20'd0, csr_waddr}, 32'h0);
    tick();
    chk("rw_idle_in_ready", {31'd0, in_ready}, 32'd1);

    // CSRRS 0x300, old 0x8, src 0x80
    offer(3'd1, 12'h300, 32'h80, 32'h0);
    csr_rdata = 32'h8;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rs_wr_wdata", csr_wdata, 32'h88);
    chk("rs_wr_wen", {31'd0, csr_wen}, 32'd1);
    tick();
    chk("rs_resp_rd_data", rd_data, 32'h8);
    // next op presented during the single RESP cycle
    offer(3'd1, 12'h300, 32'h0, 32'h0);
    tick();
    chk("rs_resp_one_cycle", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("rs0_accepted", {31'd0, in_ready}, 32'd0);
    chk("rs0_read_waddr", {20'd0, csr_waddr}, 32'h300);
    tick();
    chk("rs0_wr_wen", {31'd0, csr_wen}, 32'd0);
    chk("rs0_wr_exu_valid", {31'd0, csr_exu_valid}, 32'd1);
    tick();
    chk("rs0_resp_rd_data", rd_data, 32'h8);
    tick();

    // ECALL
    offer(3'd3, 12'h0, 32'h0, 32'h8000_0040);
    csr_mtvec = 32'h8000_0200;
    tick();
    in_valid = 1'b0;
    chk("ec_wr_wen", {31'd0, csr_wen}, 32'd1);
    chk("ec_wr_ecallen", {31'd0, csr_ecallen}, 32'd1);
    chk("ec_wr_waddr", {20'd0, csr_waddr}, 32'h341);
    chk("ec_wr_wdata", csr_wdata, 32'h8000_0040);
    chk("ec_wr_waddr_add1", {20'd0, csr_waddr_add1}, 32'h342);
    chk("ec_wr_wdata_add1", csr_wdata_add1, 32'd11);
    chk("ec_wr_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    csr_mtvec = 32'h1111_1111;
    chk("ec_resp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("ec_resp_redirect", {31'd0, redirect}, 32'd1);
    chk("ec_resp_npc", npc, 32'h8000_0200);
    chk("ec_resp_rd_data", rd_data, 32'h0);
    chk("ec_resp_ecallen", {31'd0, csr_ecallen}, 32'd0);
    tick();

    // MRET, mstatus 0x80, mepc 0x8000_0044
    offer(3'd4, 12'h123, 32'h0, 32'h0);
    csr_rdata = 32'h80;
    csr_mepc  = 32'h8000_0044;
    tick();
    in_valid = 1'b0;
    chk("mret_read_waddr", {20'd0, csr_waddr}, 32'h300);
    tick();
    csr_mepc = 32'hdead_beef;
    chk("mret_wr_waddr", {20'd0, csr_waddr}, 32'h300);
    chk("mret_wr_wdata", csr_wdata, 32'h88);
    chk("mret_wr_wen", {31'd0, csr_wen}, 32'd1);
    chk("mret_wr_waddr_add1", {20'd0, csr_waddr_add1}, 32'h0);
    tick();
    chk("mret_resp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("mret_resp_redirect", {31'd0, redirect}, 32'd1);
    chk("mret_resp_npc", npc, 32'h8000_0044);
    tick();

    // backpressure: CSRRW 0x340, old 0x55, out_ready low for 5 cycles
    out_ready = 1'b0;
    offer(3'd0, 12'h340, 32'h1234, 32'h0);
    csr_rdata = 32'h55;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    offer(3'd3, 12'h0, 32'h0, 32'h8000_0999);
    csr_rdata = 32'h77;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_rd_data", rd_data, 32'h55);
      chk("bp_npc", npc, 32'h0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_ecallen", {31'd0, csr_ecallen}, 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_still_resp", {31'd0, out_valid}, 32'd1);
    tick();
    chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("bp_no_ecall_latched", {31'd0, csr_wen}, 32'd0);
    chk("bp_still_idle", {31'd0, in_ready}, 32'd1);

    // reserved op goes straight to RESP
    offer(3'd6, 12'h305, 32'hffff_ffff, 32'h8000_0000);
    tick();
    in_valid = 1'b0;
    chk("rsv_out_valid", {31'd0, out_valid}, 32'd1);
    chk("rsv_rd_data", rd_data, 32'h0);
    chk("rsv_redirect", {31'd0, redirect}, 32'd0);
    chk("rsv_wen", {31'd0, csr_wen}, 32'd0);
    chk("rsv_exu_valid", {31'd0, csr_exu_valid}, 32'd0);
    tick();

    // reset in the middle of CSRRC WRITE
    offer(3'd2, 12'h300, 32'h0f, 32'h0);
    csr_rdata = 32'hff;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rc_wr_wen", {31'd0, csr_wen}, 32'd1);
    chk("rc_wr_wdata", csr_wdata, 32'hf0);
    #2 rst = 1'b0;
    #1;
    chk("rc_rst_wen", {31'd0, csr_wen}, 32'd0);
    chk("rc_rst_exu_valid", {31'd0, csr_exu_valid}, 32'd0);
    chk("rc_rst_wdata", csr_wdata, 32'h0);
    tick();
    rst = 1'b1;
    chk("rc_rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rc_rel_out_valid", {31'd0, out_valid}, 32'd0);

    // first op after reset, to a read-only address
    offer(3'd0, 12'hf11, 32'h1, 32'h0);
    csr_rdata = 32'h0;
    tick();
    in_valid = 1'b0;
    chk("ro_accepted", {31'd0, in_ready}, 32'd0);
    chk("ro_read_waddr", {20'd0, csr_waddr}, 32'hf11);
    tick();
    chk("ro_wr_wen", {31'd0, csr_wen}, 32'd1);
    tick();
    chk("ro_resp_rd_data", rd_data, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_exu_csr_ctrl.md
YSYX_EXU_CSR_CTRL -- requirements
Module: ysyx_exu_csr_ctrl

Interface
REQ-001 The module SHALL have parameter BIT_W, default 32, meaning the data width.
REQ-002 The module SHALL have parameter R_W, default 12, meaning the CSR address width.
REQ-003 The module SHALL have ports `clk` (in, 1): the single clock; `rst` (in, 1): asynchronous, active-low reset.
REQ-004 The module SHALL have port `in_valid` (in, 1): an operation is offered.
REQ-005 The module SHALL have port `in_ready` (out, 1): the module is able to accept an operation.
REQ-006 The module SHALL have port `op` (in, 3), encoded as: 0=CSRRW, 1=CSRRS, 2=CSRRC, 3=ECALL, 4=MRET; codes 5-7 are reserved.
REQ-007 The module SHALL have ports `csr_addr` (in, R_W), `src` (in, BIT_W) and `pc` (in, BIT_W): the CSR address, the rs1/zimm value and the instruction PC.
REQ-008 The module SHALL have ports `out_valid` (out, 1) and `out_ready` (in, 1): the result handshake.
REQ-009 The module SHALL have ports `rd_data` (out, BIT_W): the old CSR value; `redirect` (out, 1): a PC redirect is valid; `npc` (out, BIT_W): the redirect target.
REQ-010 The module SHALL have ports `csr_exu_valid` (out, 1), `csr_wen` (out, 1) and `csr_ecallen` (out, 1): the CSR file strobes.
REQ-011 The module SHALL have ports `csr_waddr` (out, R_W) and `csr_waddr_add1` (out, R_W): the primary and secondary CSR addresses.
REQ-012 The module SHALL have ports `csr_wdata` (out, BIT_W) and `csr_wdata_add1` (out, BIT_W): the primary and secondary write data.
REQ-013 The module SHALL have ports `csr_rdata`, `csr_mtvec` and `csr_mepc` (in, BIT_W each): CSR file read data, mtvec and mepc.

Function
REQ-014 The FSM SHALL have the states IDLE, READ, WRITE and RESP.
REQ-015 `in_ready` SHALL equal 1 only in IDLE.
REQ-016 An operation SHALL be accepted when in_valid&in_ready; op, csr_addr, src and pc SHALL be latched at that edge.
REQ-017 For CSRRW/CSRRS/CSRRC, the sequence SHALL be IDLE->READ->WRITE->RESP: READ lasts exactly 1 cycle, `csr_waddr`=latched addr, and csr_rdata is captured into rd_data at the end of READ.
REQ-018 In WRITE, for 1 cycle, csr_exu_valid=1 and csr_wdata=new value, where CSRRW gives src, CSRRS gives old|src, and CSRRC gives old&~src.
REQ-019 In WRITE, csr_wen SHALL be 1, except for CSRRS/CSRRC with src==0, where csr_wen=0 and no write occurs.
REQ-020 In WRITE, csr_waddr_add1 SHALL be 0 and csr_wdata_add1 SHALL be 0, so the secondary port hits no register.
REQ-021 For ECALL, the sequence SHALL be IDLE->WRITE->RESP.
REQ-022 ECALL WRITE outputs SHALL be: csr_wen=1, csr_ecallen=1, waddr=0x341 with wdata=pc, and waddr_add1=0x342 with wdata_add1=11.
REQ-023 ECALL RESP outputs SHALL be: redirect=1, npc=csr_mtvec sampled in WRITE, rd_data=0.
REQ-024 For MRET, the sequence SHALL be IDLE->READ->WRITE->RESP, with READ at addr 0x300.
REQ-025 MRET WRITE SHALL write 0x300 with the read value modified by bit3(MIE)=bit7(MPIE) and bit7=1; the secondary port SHALL be idle.
REQ-026 MRET RESP SHALL give redirect=1 and npc=csr_mepc sampled in READ.
REQ-027 A reserved op SHALL go IDLE->RESP with rd_data=0 and redirect=0, and SHALL NOT produce any CSR strobe.
REQ-028 In RESP, out_valid=1, and rd_data/redirect/npc SHALL be held stable until out_ready; at out_valid&out_ready the FSM SHALL go to IDLE.
REQ-029 If out_ready is already 1 on the first RESP cycle, RESP SHALL last 1 cycle; an operation presented in the next cycle SHALL be accepted.
REQ-030 Total latency SHALL be: CSR op 3 cycles accept-to-out_valid; ECALL 2; MRET 3; reserved 1.
REQ-031 csr_exu_valid, csr_wen and csr_ecallen SHALL be 0 in all states other than WRITE, and SHALL be single-cycle pulses per operation.
REQ-032 Outside READ and WRITE, csr_waddr and csr_waddr_add1 SHALL be 0.
REQ-033 Writes to read-only addresses (0xF11, 0xF12) or unmapped addresses SHALL still pulse csr_wen; the CSR file discards them, and rd_data SHALL be whatever csr_rdata returns (0 for unmapped).
REQ-034 in_valid while not in IDLE SHALL be ignored, with no latching.

Reset
REQ-035 Asserting rst=0 SHALL, asynchronously at any state, force: FSM=IDLE, in_ready=1, out_valid=0, redirect=0, rd_data=0, npc=0, and all csr_* outputs 0.
REQ-036 Reset during WRITE SHALL drop csr_wen the same instant; the operation is abandoned with no response.
REQ-037 After rst deasserts, the first in_valid SHALL be accepted at the next rising edge.

Verification
REQ-038 Test CSRRW: csr_addr=0x305, src=0x8000_0100, with csr_rdata=0 -> WRITE pulses wen, waddr=0x305, wdata=0x8000_0100; rd_data=0; out_valid in cycle 3.
REQ-039 Test CSRRS: addr=0x300, old=0x0000_0008, src=0x80 -> wdata=0x88; with src=0 -> csr_wen=0, rd_data=0x8.
REQ-040 Test ECALL: pc=0x8000_0040, csr_mtvec=0x8000_0200 -> waddr=0x341/wdata=0x8000_0040, waddr_add1=0x342/wdata_add1=11, ecallen=1; RESP redirect=1, npc=0x8000_0200.
REQ-041 Test MRET: mstatus read=0x80, csr_mepc=0x8000_0044 -> wdata=0x88; npc=0x8000_0044.
REQ-042 Test backpressure: out_ready=0 for 5 cycles -> out_valid, rd_data and npc are stable and in_ready=0; a second in_valid in that window is not accepted.
REQ-043 Test reset during WRITE of CSRRC: rst=0 mid-cycle -> csr_wen=0 immediately, and after release in_ready=1 and out_valid=0.
